// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding whole packets from NREQ byte sources into one UART transmitter
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_stb,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [NREQ-1:0]   grant,
  output logic              timeout_evt
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SERVE, STROBE, WAIT} state_t;
  state_t state;
  logic [IW-1:0] owner, idx, pick;
  logic [CW-1:0] cnt;
  logic last_flag, accept;
  logic [7:0] bytes [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_byte
    assign bytes[i] = req_data[8*i +: 8];
  end
  assign accept = (state == SERVE) && req_valid[owner] && !tx_busy;
  assign req_ready = accept ? NREQ'(1) << owner : '0;
  always_comb begin
    idx = owner;
    pick = owner;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
      if (req_valid[idx] && pick == owner && !req_valid[owner]) pick = idx;
      else if (req_valid[idx] && pick == owner && k != NREQ - 1 && req_valid[owner] && !(|(req_valid & found_mask(owner, idx)))) pick = idx;
    end
  end
  function automatic logic [NREQ-1:0] found_mask(input logic [IW-1:0] from, input logic [IW-1:0] upto);
    logic [NREQ-1:0] m;
    logic [IW-1:0] j;
    m = '0;
    j = from;
    for (int k = 0; k < NREQ; k++) begin
      j = (j == IW'(NREQ - 1)) ? '0 : j + 1'b1;
      if (j == upto) break;
      m[j] = 1'b1;
    end
    return m;
  endfunction
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      owner <= IW'(NREQ - 1);
      tx_stb <= 1'b0;
      tx_data <= 8'h00;
      timeout_evt <= 1'b0;
      cnt <= '0;
      last_flag <= 1'b0;
    end else begin
      tx_stb <= 1'b0;
      timeout_evt <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant <= NREQ'(1) << pick;
          owner <= pick;
          state <= SERVE;
        end
        SERVE: if (accept) begin
          tx_data <= bytes[owner];
          last_flag <= req_last[owner];
          tx_stb <= 1'b1;
          cnt <= '0;
          state <= STROBE;
        end else if (!req_valid[owner]) begin
          cnt <= (cnt == CW'(TIMEOUT - 1)) ? '0 : cnt + 1'b1;
          if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_evt <= 1'b1;
            grant <= '0;
            state <= IDLE;
          end
        end
        STROBE: state <= WAIT;
        default: if (!tx_busy) begin
          state <= last_flag ? IDLE : SERVE;
          grant <= last_flag ? '0 : grant;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic tx_stb, tx_busy, timeout_evt;
  logic [7:0] tx_data;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int stb_cyc = 0;
  int to_cyc = 0;
  int to_cnt = 0;
  int busy_len = 5;
  int bcnt = 0;
  logic force_busy = 1'b0;
  logic [3:0] to_grant;
  logic [3:0] prev_grant = '0;
  logic [3:0] acc;
  logic stb;
  logic [11:0] exp_q [$];
  logic [11:0] e;
  logic [8:0] src [4][$];
  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_stb(tx_stb),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant(grant),
    .timeout_evt(timeout_evt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  initial begin
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      stb = tx_stb;
      if (|acc) acc_cyc = cyc;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
      bcnt = stb ? busy_len : (bcnt > 0 ? bcnt - 1 : 0);
      tx_busy = force_busy || bcnt > 0;
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
        if (src[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = src[i][0][7:0];
          req_last[i] = src[i][0][8];
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (tx_stb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {grant, tx_data}, 12'h000);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_grant", grant, e[11:8]);
          chk("strobe_data", tx_data, e[7:0]);
        end
        chk("accept_to_strobe", cyc - acc_cyc, 1);
        if (grant == prev_grant) chk("byte_spacing_ok", (cyc - stb_cyc) >= 3, 1);
        prev_grant = grant;
        stb_cyc = cyc;
      end
      if (timeout_evt) begin
        to_cnt++;
        to_cyc = cyc;
        to_grant = grant;
      end
    end
  end
  task automatic drain(input string name, input int lim);
    int n = 0;
    while ((exp_q.size() + src[0].size() + src[1].size() + src[2].size() + src[3].size()) != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk(name, n < lim, 1);
    repeat (12) @(posedge clk);
    #2;
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"}, grant, 4'h0);
    chk({tag, "_tx_stb"}, tx_stb, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_timeout_evt"}, timeout_evt, 1'b0);
    chk({tag, "_req_ready"}, req_ready, 4'h0);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    src[1].push_back({1'b1, 8'h41});
    src[3].push_back({1'b1, 8'h42});
    exp_q.push_back({4'b0010, 8'h41});
    exp_q.push_back({4'b1000, 8'h42});
    drain("drain_two_singles", 200);
    src[0].push_back({1'b0, 8'hde});
    src[0].push_back({1'b0, 8'h1b});
    src[0].push_back({1'b1, 8'h32});
    src[2].push_back({1'b1, 8'h77});
    exp_q.push_back({4'b0001, 8'hde});
    exp_q.push_back({4'b0001, 8'h1b});
    exp_q.push_back({4'b0001, 8'h32});
    exp_q.push_back({4'b0100, 8'h77});
    drain("drain_packet", 300);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    src[0].push_back({1'b1, 8'ha0});
    src[0].push_back({1'b1, 8'ha4});
    src[1].push_back({1'b1, 8'ha1});
    src[2].push_back({1'b1, 8'ha2});
    src[3].push_back({1'b1, 8'ha3});
    exp_q.push_back({4'b0001, 8'ha0});
    exp_q.push_back({4'b0010, 8'ha1});
    exp_q.push_back({4'b0100, 8'ha2});
    exp_q.push_back({4'b1000, 8'ha3});
    exp_q.push_back({4'b0001, 8'ha4});
    drain("drain_round_robin", 400);
    force_busy = 1'b1;
    src[2].push_back({1'b1, 8'h55});
    exp_q.push_back({4'b0100, 8'h55});
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("busy_grant", grant, 4'b0100);
    chk("busy_req_ready", req_ready, 4'h0);
    chk("busy_no_strobe", exp_q.size(), 1);
    @(posedge clk);
    #2;
    force_busy = 1'b0;
    drain("drain_busy_release", 100);
    busy_len = 0;
    src[1].push_back({1'b0, 8'h61});
    exp_q.push_back({4'b0010, 8'h61});
    n = 0;
    while (to_cnt == 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    chk("timeout_seen", to_cnt, 1);
    chk("timeout_delay", to_cyc - stb_cyc, 18);
    chk("timeout_grant", to_grant, 4'h0);
    #2;
    src[3].push_back({1'b1, 8'h63});
    exp_q.push_back({4'b1000, 8'h63});
    drain("drain_after_timeout", 100);
    busy_len = 6;
    src[0].push_back({1'b0, 8'hc1});
    src[0].push_back({1'b0, 8'hc2});
    src[0].push_back({1'b1, 8'hc3});
    src[2].push_back({1'b1, 8'hd2});
    exp_q.push_back({4'b0001, 8'hc1});
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_byte_before_reset", n < 50, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.push_back({4'b0001, 8'hc2});
    exp_q.push_back({4'b0001, 8'hc3});
    exp_q.push_back({4'b0100, 8'hd2});
    @(negedge clk);
    check_reset_values("midpkt_reset");
    drain("drain_after_reset", 300);
    chk("leftover_expected", exp_q.size(), 0);
    chk("timeout_pulse_count", to_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles before a held grant is revoked (>=2).
REQ-003 SHALL have port wb_clk_i, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, NREQ, requester i has a byte offered.
REQ-006 SHALL have port req_data, input, 8*NREQ, byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, NREQ, offered byte ends requester i's packet.
REQ-008 SHALL have port req_ready, output, NREQ, byte of requester i accepted this cycle.
REQ-009 SHALL have port tx_stb, output, 1, one-cycle write strobe to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8, byte for the UART transmitter.
REQ-011 SHALL have port tx_busy, input, 1, UART transmitter busy.
REQ-012 SHALL have port grant, output, NREQ, one-hot current owner; all-zero when none.
REQ-013 SHALL have port timeout_evt, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 SHALL implement states IDLE, SERVE, STROBE, WAIT.
REQ-015 IDLE: if any req_valid bit set, SHALL register the grant of the first set bit searching from (last_owner+1) mod NREQ upward with wrap, update last_owner, enter SERVE; grant visible the cycle after the request is seen.
REQ-016 SERVE: req_ready[g] SHALL equal req_valid[g] & ~tx_busy combinationally; all other req_ready bits SHALL be 0 in every state.
REQ-017 SERVE accept (req_valid[g] & req_ready[g]): SHALL latch req_data byte g into tx_data and req_last[g] into a last flag, enter STROBE.
REQ-018 STROBE: tx_stb SHALL be 1 for exactly this one cycle with tx_data stable; tx_busy ignored; next state WAIT unconditionally.
REQ-019 WAIT: SHALL remain while tx_busy=1; on tx_busy=0 SHALL go to IDLE (grant cleared) if the last flag is set, else back to SERVE keeping the grant.
REQ-020 Accept-to-strobe latency SHALL be exactly 1 cycle; back-to-back bytes of one packet SHALL be spaced by no fewer than 3 cycles.
REQ-021 A packet SHALL never be interleaved with another requester's bytes: grant changes only through IDLE.
REQ-022 Timeout counter SHALL count SERVE cycles with req_valid[g]=0, clear on accept or on leaving SERVE, and at TIMEOUT-1 SHALL pulse timeout_evt, clear grant, enter IDLE.
REQ-023 tx_data SHALL hold its value outside STROBE; tx_stb SHALL be 0 outside STROBE.
REQ-024 req_valid changes on non-granted requesters during SERVE/STROBE/WAIT SHALL have no effect.
REQ-025 A single requester SHALL be re-granted when it is the only one valid in IDLE.

Reset
REQ-026 wb_rst_i=1 at a clock edge SHALL force IDLE, grant=0, req_ready=0, tx_stb=0, tx_data=8'h00, timeout_evt=0, counter=0, last flag=0, last_owner=NREQ-1 (requester 0 highest priority next).
REQ-027 Reset asserted mid-packet (any state) SHALL abandon the packet without a further tx_stb; a strobe in progress SHALL not be extended.

Verification
REQ-028 Reset, then req_valid=4'b1010, single-byte packets 8'h41/8'h42 (last=1), tx_busy high 5 cycles after each strobe -> grant 4'b0010 first, tx_stb with 8'h41, then 4'b1000 with 8'h42.
REQ-029 Requester 0 sends 3-byte packet 8'hde,8'h1b,8'h32 (last on third) while requester 2 constantly valid -> three strobes from requester 0 consecutively, then grant 4'b0100.
REQ-030 All four valid continuously, single-byte packets -> grant order 0,1,2,3,0; each exactly one tx_stb per grant.
REQ-031 Requester 1 sends non-last byte then drops req_valid, TIMEOUT=16 -> timeout_evt high one cycle 16 SERVE cycles later, grant=0, next IDLE arbitration proceeds.
REQ-032 tx_busy held high during SERVE -> req_ready=0, no tx_stb until tx_busy falls, then accept and strobe 1 cycle later.
REQ-033 wb_rst_i pulsed during WAIT of a multi-byte packet -> all outputs at reset values next cycle; next grant goes to requester 0 if valid.
